// File: rtl/shift_count_register.sv
// General-purpose datapath register: clear, load, count, shift and rotate in one cycle,
// with optional unsigned saturation and a Z/N/C/V flag set.
module shift_count_register #(
  parameter int                    DATA_WIDTH  = 8,
  parameter int                    SATURATE    = 0,
  parameter logic [DATA_WIDTH-1:0] RESET_VALUE = '0
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  ctrl_clr,
  input  logic                  ctrl_load,
  input  logic                  ctrl_incr,
  input  logic                  ctrl_decr,
  input  logic                  ctrl_shl,
  input  logic                  ctrl_shr,
  input  logic                  ctrl_rol,
  input  logic                  ctrl_ror,
  input  logic                  shift_in,
  input  logic [DATA_WIDTH-1:0] data_in,
  output logic [DATA_WIDTH-1:0] data_out,
  output logic                  flag_z,
  output logic                  flag_n,
  output logic                  flag_c,
  output logic                  flag_v
);

  localparam logic [DATA_WIDTH-1:0] ALL_ONES = {DATA_WIDTH{1'b1}};
  localparam logic [DATA_WIDTH-1:0] MAX_POS  = {1'b0, {(DATA_WIDTH-1){1'b1}}};
  localparam logic [DATA_WIDTH-1:0] MIN_NEG  = {1'b1, {(DATA_WIDTH-1){1'b0}}};
  localparam logic [DATA_WIDTH-1:0] ONE      = {{(DATA_WIDTH-1){1'b0}}, 1'b1};
  localparam bit                    SAT_EN   = (SATURATE != 0);

  logic [DATA_WIDTH-1:0] r_data;
  logic                  r_c;
  logic                  r_v;

  logic [DATA_WIDTH-1:0] w_data_next;
  logic                  w_c_next;
  logic                  w_v_next;
  logic                  w_at_max;
  logic                  w_at_zero;

  assign w_at_max  = (r_data == ALL_ONES);
  assign w_at_zero = (r_data == '0);

  // Priority chain: only the highest asserted control executes; nothing asserted holds.
  always_comb begin
    w_data_next = r_data;
    w_c_next    = r_c;
    w_v_next    = r_v;
    if (ctrl_clr) begin
      w_data_next = '0;
      w_c_next    = 1'b0;
      w_v_next    = 1'b0;
    end else if (ctrl_load) begin
      w_data_next = data_in;
      w_c_next    = 1'b0;
      w_v_next    = 1'b0;
    end else if (ctrl_incr) begin
      w_c_next = w_at_max;
      w_v_next = (r_data == MAX_POS);
      if (SAT_EN && w_at_max) begin
        w_data_next = r_data;
      end else begin
        w_data_next = r_data + ONE;
      end
    end else if (ctrl_decr) begin
      w_c_next = w_at_zero;
      w_v_next = (r_data == MIN_NEG);
      if (SAT_EN && w_at_zero) begin
        w_data_next = r_data;
      end else begin
        w_data_next = r_data - ONE;
      end
    end else if (ctrl_shl) begin
      w_data_next = {r_data[DATA_WIDTH-2:0], shift_in};
      w_c_next    = r_data[DATA_WIDTH-1];
      w_v_next    = r_data[DATA_WIDTH-1] ^ r_data[DATA_WIDTH-2];
    end else if (ctrl_shr) begin
      w_data_next = {shift_in, r_data[DATA_WIDTH-1:1]};
      w_c_next    = r_data[0];
      w_v_next    = 1'b0;
    end else if (ctrl_rol) begin
      w_data_next = {r_data[DATA_WIDTH-2:0], r_data[DATA_WIDTH-1]};
      w_c_next    = r_data[DATA_WIDTH-1];
      w_v_next    = 1'b0;
    end else if (ctrl_ror) begin
      w_data_next = {r_data[0], r_data[DATA_WIDTH-1:1]};
      w_c_next    = r_data[0];
      w_v_next    = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_data <= RESET_VALUE;
      r_c    <= 1'b0;
      r_v    <= 1'b0;
    end else begin
      r_data <= w_data_next;
      r_c    <= w_c_next;
      r_v    <= w_v_next;
    end
  end

  // Z and N are derived from the live register so they can never lag data_out.
  assign data_out = r_data;
  assign flag_z   = (r_data == '0);
  assign flag_n   = r_data[DATA_WIDTH-1];
  assign flag_c   = r_c;
  assign flag_v   = r_v;

endmodule

// File: doc/shift_count_register.md
Name: shift_count_register

Overview:
Parametrised general-purpose datapath register, the successor to the basic load/increment register. Adds clear, decrement, logical shifts with a serial input, rotates, optional unsigned saturation, and a flag set (Z, N, C, V). Intended for CPU accumulator, index and temp registers where ALU-free counting, shifting and flag generation are needed.

Parameters:
DATA_WIDTH, 8, register width in bits (>= 2)
SATURATE, 0, 0 = incr/decr wrap modulo 2^DATA_WIDTH; 1 = incr/decr saturate at all-ones/zero (unsigned)
RESET_VALUE, 0, value loaded into data_out on reset (DATA_WIDTH bits)

Ports:
clk  input  1  clock; all state changes on rising edge
rst  input  1  synchronous, active-high reset
ctrl_clr  input  1  clear register to zero
ctrl_load  input  1  load data_in
ctrl_incr  input  1  increment by 1
ctrl_decr  input  1  decrement by 1
ctrl_shl  input  1  shift left by 1; shift_in enters bit 0
ctrl_shr  input  1  logical shift right by 1; shift_in enters MSB
ctrl_rol  input  1  rotate left by 1
ctrl_ror  input  1  rotate right by 1
shift_in  input  1  serial bit for shl/shr
data_in  input  DATA_WIDTH  parallel load value
data_out  output  DATA_WIDTH  register contents
flag_z  output  1  data_out == 0 (combinational from register)
flag_n  output  1  data_out[MSB] (combinational from register)
flag_c  output  1  registered carry/borrow/shifted-out bit
flag_v  output  1  registered signed overflow

Behaviour:
- Reset: rst = 1 at a rising edge -> data_out = RESET_VALUE, flag_c = 0, flag_v = 0; rst overrides all controls. Any operation in progress is discarded; no state survives.
- Single-cycle latency: the result of an op asserted in cycle n is visible on data_out/flags after edge n+1.
- Fixed priority when several controls are high (only the highest one executes): clr > load > incr > decr > shl > shr > rol > ror.
- No control high: data_out, flag_c and flag_v hold.
- clr: data_out = 0, C = 0, V = 0.
- load: data_out = data_in, C = 0, V = 0.
- incr (SATURATE=0): data_out = data_out+1 mod 2^W. C = 1 iff data_out was all-ones (wrap to 0). V = 1 iff data_out was 0111..1 (-> 1000..0).
- decr (SATURATE=0): data_out = data_out-1 mod 2^W. C = 1 (borrow) iff data_out was 0 (-> all-ones). V = 1 iff data_out was 1000..0 (-> 0111..1).
- incr (SATURATE=1) at all-ones: value unchanged, C = 1, V = 0. Otherwise identical to the wrap case, including V.
- decr (SATURATE=1) at 0: value unchanged, C = 1, V = 0. Otherwise identical to the wrap case.
- shl: data_out = {data_out[W-2:0], shift_in}. C = old MSB. V = old MSB XOR old bit W-2 (sign change).
- shr: data_out = {shift_in, data_out[W-1:1]}. C = old bit 0. V = 0.
- rol: data_out = {data_out[W-2:0], data_out[W-1]}. C = old MSB. V = 0.
- ror: data_out = {data_out[0], data_out[W-1:1]}. C = old bit 0. V = 0.
- flag_z and flag_n always reflect the current data_out and are never stale. flag_c and flag_v describe the last executed op, including clr and load.
- Width rules: all arithmetic is DATA_WIDTH bits; no truncation warnings. RESET_VALUE is sized to DATA_WIDTH.

Test Plan:
- Reset with RESET_VALUE=8'hA5, all controls high -> data_out=A5, C=V=0, Z=0, N=1. Release rst -> next edge executes clr: data_out=00, Z=1.
- W=8, SATURATE=0: load 7F, then incr -> 80, V=1, C=0, N=1. Load FF, then incr -> 00, C=1, Z=1. Load 00, then decr -> FF, C=1. Load 80, then decr -> 7F, V=1.
- W=8, SATURATE=1: load FE, then incr x3 -> FF, FF, FF with C=0,1,1. Load 01, then decr x2 -> 00 (C=0), 00 (C=1).
- Shifts: load 81. shl with shift_in=0 -> 02, C=1, V=1. shr with shift_in=1 -> 81, C=0, V=0. rol -> 03, C=1. ror -> 81, C=1.
- Priority: load=1, incr=1, data_in=10 -> 10. incr=1, decr=1 from 10 -> 11. shl=1, ror=1 from 11, shift_in=0 -> 22. No controls for 3 cycles -> 22 and flags hold.
- Mid-operation reset: incr held high for 5 cycles from 00, rst pulsed in cycle 3 -> data_out returns to RESET_VALUE, then increments resume the cycle after rst drops. Repeat with W=16 and a wrap at FFFF.
